// File: rtl/ctrl_mc.sv
// ---------------------------------------------------------------------------
// ctrl_mc -- multi-cycle control unit for the rysy RV32I core.
//
// Sequences IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH over a
// unified req/ack memory port. A memory wait that runs MEM_TIMEOUT cycles
// traps with bus_err. An undefined opcode traps with illegal. TRAP holds
// until rst.
//
// Parameters
//   MEM_TIMEOUT  cycles mem_req may stay high without mem_ack (2..255)
//   INSTRET_W    width of the retired-instruction counter (CTRL_PERF_EN only)
//
// Optional feature
//   `define CTRL_PERF_EN  adds output instret, a wrapping count of retired
//                         instructions. Without it the port does not exist.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   opcode/func3/   instr[6:2], instr[14:12], instr[31:25]; sampled only in
//   func7           DECODE
//   b               branch-compare result, used in EXEC of a BRANCH
//   mem_ack         memory acknowledge
//   mem_req/mem_we  memory request / write enable
//   ir_wr           load instruction register (FETCH with ack)
//   imm_type        immediate-mux select (IMM_* encoding below)
//   alu_op          {sub/sra bit, func3}
//   alu2_sel        0 = rs2, 1 = immediate
//   rd_sel          0 = alu, 1 = mem, 2 = pc+4, 3 = imm
//   pc_wr/pc_sel    PC update strobe; 0 = pc+4, 1 = pc+imm, 2 = alu
//   reg_wr          register-file write strobe
//   state           current FSM state (debug)
//   illegal/bus_err sticky trap causes
// ---------------------------------------------------------------------------
module ctrl_mc #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           opcode,
  input  logic [2:0]           func3,
  input  logic [6:0]           func7,
  input  logic                 b,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_wr,
  output logic [2:0]           imm_type,
  output logic [3:0]           alu_op,
  output logic                 alu2_sel,
  output logic [1:0]           rd_sel,
  output logic                 pc_wr,
  output logic [1:0]           pc_sel,
  output logic                 reg_wr,
`ifdef CTRL_PERF_EN
  output logic [INSTRET_W-1:0] instret,
`endif
  output logic [2:0]           state,
  output logic                 illegal,
  output logic                 bus_err
);

  // Immediate-mux encoding shared with the datapath.
  localparam logic [2:0] IMM_DEFAULT = 3'd0;
  localparam logic [2:0] IMM_I       = 3'd1;
  localparam logic [2:0] IMM_S       = 3'd2;
  localparam logic [2:0] IMM_B       = 3'd3;
  localparam logic [2:0] IMM_U       = 3'd4;
  localparam logic [2:0] IMM_J       = 3'd5;

  // RV32I major opcodes, instr[6:2].
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  state_t     cur;
  logic [4:0] op_q;      // opcode latched in DECODE; drives EXEC/MEM/WB
  logic [7:0] tmo_cnt;   // cycles spent waiting for mem_ack

  // Only func7[5] distinguishes SUB/SRA/SRAI; the rest of func7 is unused.
  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};

  // -------------------------------------------------------------------------
  // Instruction decode from the live IR fields, consumed only in DECODE.
  // -------------------------------------------------------------------------
  logic       dec_legal;
  logic [2:0] dec_imm;
  logic [3:0] dec_alu_op;
  logic       dec_alu2;
  logic [1:0] dec_rd;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    dec_legal  = 1'b1;
    dec_imm    = IMM_DEFAULT;
    dec_alu_op = 4'd0;
    dec_alu2   = 1'b1;
    dec_rd     = 2'd0;
    case (opcode)
      OPC_OP_IMM: begin
        dec_imm    = IMM_I;
        // Only SRLI/SRAI carry an arithmetic-shift bit in func7.
        dec_alu_op = {(func3 == 3'b101) & func7[5], func3};
      end
      OPC_JALR: begin
        dec_imm = IMM_I;
        dec_rd  = 2'd2;
      end
      OPC_LOAD: begin
        dec_imm = IMM_I;
        dec_rd  = 2'd1;
      end
      OPC_STORE:  dec_imm = IMM_S;
      OPC_BRANCH: begin
        dec_imm  = IMM_B;
        dec_alu2 = 1'b0;
      end
      OPC_LUI: begin
        dec_imm = IMM_U;
        dec_rd  = 2'd3;
      end
      OPC_AUIPC:  dec_imm = IMM_U;
      OPC_JAL: begin
        dec_imm = IMM_J;
        dec_rd  = 2'd2;
      end
      OPC_OP: begin
        dec_alu_op = {func7[5], func3};
        dec_alu2   = 1'b0;
      end
      default:    dec_legal = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer: state, latched instruction, registered selects, trap flags.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= S_IDLE;
      op_q     <= 5'd0;
      tmo_cnt  <= 8'd0;
      imm_type <= IMM_DEFAULT;
      alu_op   <= 4'd0;
      alu2_sel <= 1'b0;
      rd_sel   <= 2'd0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // sees the pre-edge values of cur, op_q and tmo_cnt.
      case (cur)
        S_IDLE: cur <= S_FETCH;

        // Both memory phases share the handshake and timeout; an ack in the
        // terminal-count cycle is tested first and therefore wins.
        S_FETCH, S_MEM: begin
          if (mem_ack) begin
            tmo_cnt <= 8'd0;
            if (cur == S_FETCH)          cur <= S_DECODE;
            else if (op_q == OPC_STORE)  cur <= S_FETCH;
            else                         cur <= S_WB;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt <= 8'd0;
            bus_err <= 1'b1;
            cur     <= S_TRAP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        S_DECODE: begin
          op_q     <= opcode;
          imm_type <= dec_imm;
          alu_op   <= dec_alu_op;
          alu2_sel <= dec_alu2;
          rd_sel   <= dec_rd;
          if (dec_legal) begin
            cur <= S_EXEC;
          end else begin
            illegal <= 1'b1;
            cur     <= S_TRAP;
          end
        end

        S_EXEC: begin
          if (op_q == OPC_BRANCH)                           cur <= S_FETCH;
          else if (op_q == OPC_LOAD || op_q == OPC_STORE)   cur <= S_MEM;
          else                                              cur <= S_WB;
        end

        S_WB:    cur <= S_FETCH;
        S_TRAP:  cur <= S_TRAP;
        default: cur <= S_TRAP;
      endcase
    end
  end

  assign state = cur;

  // -------------------------------------------------------------------------
  // Strobes decoded from the current state. ir_wr, the store's pc_wr and the
  // branch pc_sel depend on same-cycle mem_ack / b, so they cannot be
  // registered one cycle early. TRAP and IDLE fall through to all-zero.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    pc_sel  = 2'd0;
    reg_wr  = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_wr   = mem_ack;
      end
      S_EXEC: begin
        if (op_q == OPC_BRANCH) begin
          pc_wr  = 1'b1;
          pc_sel = {1'b0, b};
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OPC_STORE);
        pc_wr   = (op_q == OPC_STORE) & mem_ack;
      end
      S_WB: begin
        reg_wr = 1'b1;
        pc_wr  = 1'b1;
        if (op_q == OPC_JAL)       pc_sel = 2'd1;
        else if (op_q == OPC_JALR) pc_sel = 2'd2;
      end
      default: ;
    endcase
  end

`ifdef CTRL_PERF_EN
  // An instruction retires in its last cycle: WB, a BRANCH's EXEC, or the
  // acknowledged MEM cycle of a STORE.
  logic retire;
  assign retire = (cur == S_WB)
                | ((cur == S_EXEC) & (op_q == OPC_BRANCH))
                | ((cur == S_MEM) & (op_q == OPC_STORE) & mem_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret <= '0;
    else if (retire) instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
  end
`else
  localparam int unused_instret_w = INSTRET_W;
`endif

endmodule
